// File: rtl/log2_result_pack_if.sv
// Handshake bundle between the log2 stage, the result collector and its consumer.
// Valid/ready: a result transfers on any clock edge where valid_o and ready_i are both 1.
`timescale 1ns/1ps
interface log2_result_pack_if #(
  parameter int FRAC_W = 12
);
  logic                start_i;
  logic [3:0]          int_i;
  logic                bit_valid_i;
  logic                bit_i;
  logic                ready_i;
  logic [FRAC_W+3:0]   result_o;
  logic                valid_o;
  logic                busy_o;
  logic [3:0]          cnt_o;
  logic                err_o;
  logic [1:0]          state_o;

  modport master (
    output start_i, int_i, bit_valid_i, bit_i, ready_i,
    input  result_o, valid_o, busy_o, cnt_o, err_o, state_o
  );

  modport slave (
    input  start_i, int_i, bit_valid_i, bit_i, ready_i,
    output result_o, valid_o, busy_o, cnt_o, err_o, state_o
  );
endinterface

// File: rtl/log2_result_pack.sv
// Collects the integer part and serial fractional bits of a log2 result into
// a Q4.FRAC_W word and offers it on a valid/ready handshake.
`timescale 1ns/1ps
module log2_result_pack #(
  parameter int FRAC_W = 12
) (
  input  logic clk_i,
  input  logic rst_i,
  log2_result_pack_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(FRAC_W - 1);

  state_t              r_state;
  logic [3:0]          r_int;
  logic [FRAC_W-1:0]   r_frac;
  logic [3:0]          r_cnt;
  logic                r_err;

  state_t              w_state_nxt;
  logic [3:0]          w_int_nxt;
  logic [FRAC_W-1:0]   w_frac_nxt;
  logic [3:0]          w_cnt_nxt;
  logic                w_err_nxt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_int   <= '0;
      r_frac  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_int   <= w_int_nxt;
      r_frac  <= w_frac_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_int_nxt   = r_int;
    w_frac_nxt  = r_frac;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start_i) begin
          w_int_nxt   = bus.int_i;
          w_frac_nxt  = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        // A start here aborts the conversion; any coincident bit is dropped.
        if (bus.start_i) begin
          w_err_nxt  = 1'b1;
          w_int_nxt  = bus.int_i;
          w_frac_nxt = '0;
          w_cnt_nxt  = '0;
        end else if (bus.bit_valid_i) begin
          w_frac_nxt = (r_frac << 1) | FRAC_W'(bus.bit_i);
          w_cnt_nxt  = r_cnt + 4'd1;
          if (r_cnt == LAST_CNT) begin
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.ready_i) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
          if (bus.start_i) begin
            w_int_nxt   = bus.int_i;
            w_frac_nxt  = '0;
            w_state_nxt = COLLECT;
          end
        end else if (bus.start_i) begin
          w_err_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.result_o = {r_int, r_frac};
  assign bus.valid_o  = (r_state == HOLD);
  assign bus.busy_o   = (r_state == COLLECT);
  assign bus.cnt_o    = r_cnt;
  assign bus.err_o    = r_err;
  assign bus.state_o  = r_state;

endmodule
